// File: rtl/fsk_div_sched_pkg.sv
// Shared types and helpers for the FSK symbol scheduler and its carrier divider.
package fsk_div_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsk_state_t;

    localparam int DIV_SPACE_DEF = 16;
    localparam int DIV_MARK_DEF  = 8;

    // Even ratio of at least 2, so the carrier half-period is never zero.
    function automatic logic [31:0] sanitise_ratio(input logic [31:0] ratio);
        logic [31:0] r;
        r = {ratio[31:1], 1'b0};
        if (r < 32'd2) begin
            r = 32'd2;
        end
        return r;
    endfunction

endpackage

// File: rtl/fsk_div_sched_if.sv
// Bit-source handshake into the FSK scheduler: one symbol bit per valid/ready transfer.
interface fsk_div_sched_if;
    logic bit_valid;
    logic bit_data;
    logic bit_ready;

    modport master (output bit_valid, output bit_data, input bit_ready);
    modport slave  (input bit_valid, input bit_data, output bit_ready);
endinterface

// File: rtl/fsk_car_div.sv
// Loadable half-period toggle divider: carrier toggles every 'half' cycles while run=1.
// load or !run clears the counter and carrier for the following cycle.
module fsk_car_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] half,
    output logic             carrier
);

    logic [DIV_W-1:0] car_cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            car_cnt <= '0;
            carrier <= 1'b0;
        end else if (load || !run) begin
            car_cnt <= '0;
            carrier <= 1'b0;
        end else if (car_cnt == half - DIV_W'(1)) begin
            car_cnt <= '0;
            carrier <= ~carrier;
        end else begin
            car_cnt <= car_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/fsk_div_sched.sv
// FSK symbol sequencer: accepts a bit, then runs the selected divided carrier for SYM_CYC cycles.
// sym_start follows acceptance by 1 cycle; bit_ready only in IDLE or the last symbol cycle, gated by en.
module fsk_div_sched
    import fsk_div_sched_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int SYM_CYC = 64,
    parameter int SYM_W   = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_space,
    input  logic [DIV_W-1:0] div_mark,
    fsk_div_sched_if.slave   bit_if,
    output logic             fsk_out,
    output logic             sym_start,
    output logic             busy,
    output logic             underrun
);

    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_CYC - 1);

    fsk_state_t       state, state_nxt;
    logic [SYM_W-1:0] sym_cnt, sym_cnt_nxt;
    logic [DIV_W-1:0] half, half_nxt;
    logic             underrun_q, underrun_nxt;
    logic             ready_arm;
    logic             last, accept, car_run;
    logic [DIV_W-1:0] ratio_sel, acc_half;

    assign last      = (state == RUN) && (sym_cnt == SYM_LAST);
    // ready_arm holds bit_ready low until the first edge after reset release
    assign bit_if.bit_ready = ready_arm && en && ((state == IDLE) || last);
    assign accept    = bit_if.bit_valid && bit_if.bit_ready;
    assign ratio_sel = bit_if.bit_data ? div_mark : div_space;
    assign acc_half  = DIV_W'(sanitise_ratio(32'(ratio_sel)) >> 1);

    always_comb begin
        state_nxt    = state;
        sym_cnt_nxt  = sym_cnt;
        half_nxt     = half;
        underrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = RUN;
                    sym_cnt_nxt = '0;
                    half_nxt    = acc_half;
                end
            end
            RUN: begin
                if (last) begin
                    underrun_nxt = en && !accept;
                    sym_cnt_nxt  = '0;
                    if (accept) begin
                        half_nxt = acc_half;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    sym_cnt_nxt = sym_cnt + SYM_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sym_cnt    <= '0;
            half       <= '0;
            underrun_q <= 1'b0;
            ready_arm  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sym_cnt    <= sym_cnt_nxt;
            half       <= half_nxt;
            underrun_q <= underrun_nxt;
            ready_arm  <= 1'b1;
        end
    end

    // Carrier keeps counting only while the symbol continues; a restart or return to IDLE zeroes it.
    assign car_run = (state == RUN) && !last;

    fsk_car_div #(.DIV_W(DIV_W)) u_car (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .load    (accept),
        .run     (car_run),
        .half    (half),
        .carrier (fsk_out)
    );

    assign busy      = (state == RUN);
    assign sym_start = (state == RUN) && (sym_cnt == '0);
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_fsk_div_sched.sv
// Bench for fsk_div_sched: per-cycle reference model on two instances plus directed symbol scenarios.
module tb_fsk_div_sched;
    import fsk_div_sched_pkg::*;

    localparam int SYM_A = 64;
    localparam int SYM_B = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [7:0] dsp_a, dmk_a, dsp_b, dmk_b;
    logic       fsk_a, ss_a, busy_a, ur_a;
    logic       fsk_b, ss_b, busy_b, ur_b;
    int         tests = 0;
    int         fails = 0;

    fsk_div_sched_if ifa ();
    fsk_div_sched_if ifb ();

    always #5 clk = ~clk;

    fsk_div_sched #(.DIV_W(8), .SYM_CYC(SYM_A), .SYM_W(8)) dut_a (
        .clk_in(clk), .rst_n(rst_n), .en(en_a), .div_space(dsp_a), .div_mark(dmk_a),
        .bit_if(ifa), .fsk_out(fsk_a), .sym_start(ss_a), .busy(busy_a), .underrun(ur_a));

    fsk_div_sched #(.DIV_W(8), .SYM_CYC(SYM_B), .SYM_W(8)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .en(en_b), .div_space(dsp_b), .div_mark(dmk_b),
        .bit_if(ifb), .fsk_out(fsk_b), .sym_start(ss_b), .busy(busy_b), .underrun(ur_b));

    // Reference model: position k within the current symbol and its half-period h.
    typedef struct {
        bit busy;
        int k;
        int h;
        bit ur;
        bit ok;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t mreset();
        mstate_t s;
        s.busy = 0; s.k = 0; s.h = 0; s.ur = 0; s.ok = 0;
        return s;
    endfunction

    function automatic int half_of(input int v);
        int r;
        r = v - (v % 2);
        if (r < 2) r = 2;
        return r / 2;
    endfunction

    function automatic logic [4:0] mexp(input mstate_t s, input logic en, input int sym);
        logic rdy, f;
        rdy = s.ok && en && (!s.busy || s.k == sym - 1);
        f = 1'b0;
        if (s.busy) f = ((s.k / s.h) % 2) == 1;
        return {rdy, f, s.busy && (s.k == 0), s.busy, s.ur};
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic en, input logic vld,
                                      input logic d, input int dsp, input int dmk, input int sym);
        mstate_t n;
        logic last, rdy, acc;
        n    = s;
        last = s.busy && (s.k == sym - 1);
        rdy  = s.ok && en && (!s.busy || last);
        acc  = vld && rdy;
        n.ok = 1;
        n.ur = last && !acc && en;
        if (acc) begin
            n.busy = 1; n.k = 0; n.h = half_of(d ? dmk : dsp);
        end else if (last) begin
            n.busy = 0; n.k = 0;
        end else if (s.busy) begin
            n.k = s.k + 1;
        end
        return n;
    endfunction

    always @(negedge clk) begin : mon
        logic [4:0] ea, eb, ga, gb;
        if (!rst_n) begin
            ma = mreset();
            mb = mreset();
        end
        ea = mexp(ma, en_a, SYM_A);
        ga = {ifa.bit_ready, fsk_a, ss_a, busy_a, ur_a};
        tests++;
        if (ga !== ea) begin
            fails++;
            $display("FAIL mon_a t=%0t rdy/fsk/ss/busy/ur got %b expected %b", $time, ga, ea);
        end
        eb = mexp(mb, en_b, SYM_B);
        gb = {ifb.bit_ready, fsk_b, ss_b, busy_b, ur_b};
        tests++;
        if (gb !== eb) begin
            fails++;
            $display("FAIL mon_b t=%0t rdy/fsk/ss/busy/ur got %b expected %b", $time, gb, eb);
        end
        if (rst_n) begin
            ma = mstep(ma, en_a, ifa.bit_valid, ifa.bit_data, int'(dsp_a), int'(dmk_a), SYM_A);
            mb = mstep(mb, en_b, ifb.bit_valid, ifb.bit_data, int'(dsp_b), int'(dmk_b), SYM_B);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit c_fsk [200];
    bit c_ss  [200];
    bit c_busy[200];
    bit c_rdy [200];
    bit c_ur  [200];

    // Returns on the sym_start cycle of the accepted bit.
    task automatic send_a(input logic d, input bit keep);
        int n = 0;
        ifa.bit_valid = 1'b1;
        ifa.bit_data  = d;
        #1;
        while (!ifa.bit_ready && n < 300) begin
            tick();
            n++;
        end
        chk("accept_wait_a", int'(n < 300), 1);
        tick();
        if (!keep) ifa.bit_valid = 1'b0;
    endtask

    task automatic cap_a(input int n, input int en_off, input int vld_off);
        for (int k = 0; k < n; k++) begin
            if (k == en_off) en_a = 1'b0;
            if (k == vld_off) ifa.bit_valid = 1'b0;
            #1;
            c_fsk[k] = fsk_a; c_ss[k] = ss_a; c_busy[k] = busy_a;
            c_rdy[k] = ifa.bit_ready; c_ur[k] = ur_a;
            tick();
        end
    endtask

    typedef struct {
        logic [7:0] div;
        int         half;
    } rvec_t;

    rvec_t rv[7];

    initial begin
        int cnt, cnt2, first;

        rv[0] = '{8'd0, 1};   rv[1] = '{8'd7, 3};   rv[2] = '{8'd3, 1};
        rv[3] = '{8'd1, 1};   rv[4] = '{8'd9, 4};   rv[5] = '{8'd100, 50};
        rv[6] = '{8'd2, 1};

        rst_n = 1'b1;
        en_a = 1'b1; en_b = 1'b1;
        dsp_a = 8'(DIV_SPACE_DEF); dmk_a = 8'(DIV_MARK_DEF);
        dsp_b = 8'd8; dmk_b = 8'd8;
        ifa.bit_valid = 1'b0; ifa.bit_data = 1'b0;
        ifb.bit_valid = 1'b0; ifb.bit_data = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chkb("rst_ready", ifa.bit_ready, 1'b0);
        chkb("rst_busy", busy_a, 1'b0);
        chkb("rst_fsk", fsk_a, 1'b0);
        chkb("rst_sym_start", ss_a, 1'b0);
        chkb("rst_underrun", ur_a, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        #1 chkb("ready_before_first_edge", ifa.bit_ready, 1'b0);
        tick();
        chkb("ready_first_edge", ifa.bit_ready, 1'b1);
        chkb("fsk_after_release", fsk_a, 1'b0);

        // Asynchronous reset in the middle of a mark symbol
        send_a(1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        chkb("pre_reset_fsk", fsk_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkb("midrun_rst_busy", busy_a, 1'b0);
        chkb("midrun_rst_fsk", fsk_a, 1'b0);
        chkb("midrun_rst_ready", ifa.bit_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chkb("ready_after_rerelease", ifa.bit_ready, 1'b1);

        // Single space bit, ratio 16
        send_a(1'b0, 1'b0);
        cap_a(66, -1, -1);
        cnt = 0; cnt2 = 0;
        for (int k = 0; k < 66; k++) if (c_busy[k]) cnt++;
        for (int k = 1; k < 64; k++) if (c_fsk[k] != c_fsk[k-1]) cnt2++;
        chkb("space_sym_start", c_ss[0], 1'b1);
        chkb("space_fsk7", c_fsk[7], 1'b0);
        chkb("space_fsk8", c_fsk[8], 1'b1);
        chkb("space_fsk16", c_fsk[16], 1'b0);
        chkb("space_fsk63", c_fsk[63], 1'b1);
        chk("space_busy_len", cnt, 64);
        chk("space_toggles", cnt2, 7);
        chkb("space_idle_fsk", c_fsk[64], 1'b0);
        chkb("space_underrun", c_ur[64], 1'b1);
        chkb("space_ur_early", c_ur[63], 1'b0);
        chkb("space_ur_pulse_end", c_ur[65], 1'b0);

        // Back-to-back mark then space, valid held high
        dmk_a = 8'd8; dsp_a = 8'd16;
        send_a(1'b1, 1'b1);
        ifa.bit_data = 1'b0;
        cap_a(130, -1, 64);
        cnt = 0; first = -1;
        for (int k = 0; k < 63; k++) if (c_rdy[k]) cnt++;
        for (int k = 1; k < 130; k++) if (c_ss[k] && first < 0) first = k;
        chk("b2b_ready_early", cnt, 0);
        chkb("b2b_ready_last", c_rdy[63], 1'b1);
        chk("b2b_second_start", first, 64);
        chkb("b2b_fsk3", c_fsk[3], 1'b0);
        chkb("b2b_fsk4", c_fsk[4], 1'b1);
        chkb("b2b_fsk63", c_fsk[63], 1'b1);
        chkb("b2b_fsk64", c_fsk[64], 1'b0);
        chkb("b2b_fsk71", c_fsk[71], 1'b0);
        chkb("b2b_fsk72", c_fsk[72], 1'b1);
        chkb("b2b_busy127", c_busy[127], 1'b1);
        chkb("b2b_busy128", c_busy[128], 1'b0);
        chkb("b2b_underrun", c_ur[128], 1'b1);

        // Enable drops at cycle 20 with a bit still offered
        send_a(1'b0, 1'b1);
        cap_a(67, 20, -1);
        cnt = 0; cnt2 = 0; first = 0;
        for (int k = 0; k < 67; k++) begin
            if (c_busy[k]) cnt++;
            if (c_rdy[k]) cnt2++;
            if (c_ur[k]) first++;
        end
        chk("endrop_busy_len", cnt, 64);
        chk("endrop_ready", cnt2, 0);
        chk("endrop_underrun", first, 0);
        chkb("endrop_idle", c_busy[66], 1'b0);
        ifa.bit_valid = 1'b0;
        en_a = 1'b1;
        tick();

        // Ratio sanitising table; div_mark altered right after acceptance
        for (int i = 0; i < 7; i++) begin
            dmk_a = rv[i].div;
            send_a(1'b1, 1'b0);
            dmk_a = 8'd200;
            cap_a(66, -1, -1);
            first = -1; cnt = 0;
            for (int k = 0; k < 64; k++) if (c_fsk[k] && first < 0) first = k;
            for (int k = 1; k < 64; k++) if (c_fsk[k] != c_fsk[k-1]) cnt++;
            chk($sformatf("ratio_first_toggle_%0d", i), first, rv[i].half);
            chk($sformatf("ratio_toggle_count_%0d", i), cnt, 63 / rv[i].half);
        end

        // Short symbols: truncated carrier, then a toggle coinciding with symbol end
        ifb.bit_valid = 1'b1; ifb.bit_data = 1'b0;
        cnt = 0;
        #1;
        while (!ifb.bit_ready && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("accept_wait_b", int'(cnt < 100), 1);
        tick();
        for (int k = 0; k < 32; k++) begin
            if (k == 1) dsp_b = 8'd6;
            if (k == 20) ifb.bit_valid = 1'b0;
            #1;
            c_fsk[k] = fsk_b; c_ss[k] = ss_b; c_busy[k] = busy_b;
            tick();
        end
        chkb("trunc_fsk3", c_fsk[3], 1'b0);
        chkb("trunc_fsk4", c_fsk[4], 1'b1);
        chkb("trunc_fsk7", c_fsk[7], 1'b1);
        chkb("trunc_fsk8", c_fsk[8], 1'b0);
        chkb("trunc_restart_ss", c_ss[10], 1'b1);
        chkb("trunc_restart_fsk", c_fsk[10], 1'b0);
        chkb("trunc_fsk13", c_fsk[13], 1'b1);
        chkb("trunc_fsk19", c_fsk[19], 1'b1);
        chkb("coincide_restart_fsk", c_fsk[20], 1'b0);
        chkb("coincide_restart_ss", c_ss[20], 1'b1);
        chkb("trunc_busy29", c_busy[29], 1'b1);
        chkb("trunc_busy30", c_busy[30], 1'b0);

        // Random traffic on both instances, checked every cycle by the monitor
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            en_a = ($urandom_range(0, 9) != 0);
            en_b = ($urandom_range(0, 9) != 0);
            ifa.bit_valid = ($urandom_range(0, 3) != 0);
            ifb.bit_valid = ($urandom_range(0, 3) != 0);
            ifa.bit_data = 1'($urandom_range(0, 1));
            ifb.bit_data = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) dsp_a = 8'($urandom_range(0, 24));
            if ($urandom_range(0, 15) == 0) dmk_a = 8'($urandom_range(0, 24));
            if ($urandom_range(0, 7) == 0) dsp_b = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) dmk_b = 8'($urandom_range(0, 12));
            tick();
        end
        rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
